// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters and a saturating mispredict count.
// Lookup is combinational from current state; updates land on the clock edge with no backpressure.
module btb_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 12,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_next,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_mispredict,
  input  logic             flush,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic              upd_hit;
  logic              entry_we;
  logic              valid_d;
  logic [TAG_W-1:0]  tag_d;
  logic [PC_W-1:0]   target_d;
  logic [1:0]        ctr_d;

  // PC bits [1:0] never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  assign pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken = pred_hit && ctr_q[lk_idx][1];
  assign pred_next  = pred_taken ? target_q[lk_idx] : lk_pc + PC_W'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    entry_we = 1'b0;
    valid_d  = valid_q[upd_idx];
    tag_d    = tag_q[upd_idx];
    target_d = target_q[upd_idx];
    ctr_d    = ctr_q[upd_idx];
    if (upd_valid && !flush) begin
      if (upd_hit) begin
        entry_we = 1'b1;
        if (upd_taken) begin
          target_d = upd_target;
          if (ctr_q[upd_idx] != 2'b11) ctr_d = ctr_q[upd_idx] + 2'd1;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        entry_we = 1'b1;
        valid_d  = 1'b1;
        tag_d    = upd_tag;
        target_d = upd_target;
        ctr_d    = 2'b10;
      end
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid && upd_mispredict && (mispred_cnt_q != {CNT_W{1'b1}}))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      mispred_cnt_q <= '0;
    end else begin
      // Flush wins over any update on the same edge; counters and targets survive it.
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (entry_we) begin
        valid_q[upd_idx]  <= valid_d;
        tag_q[upd_idx]    <= tag_d;
        target_q[upd_idx] <= target_d;
        ctr_q[upd_idx]    <= ctr_d;
      end
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized scoreboard bench for btb_predictor against a table-level reference model.
module tb_btb_predictor;
  localparam int ENTRIES = 16;
  localparam int PC_W    = 12;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PC_W-1:0]  lk_pc = '0;
  logic             pred_hit, pred_taken;
  logic [PC_W-1:0]  pred_next;
  logic             upd_valid = 1'b0;
  logic [PC_W-1:0]  upd_pc = '0;
  logic             upd_taken = 1'b0;
  logic [PC_W-1:0]  upd_target = '0;
  logic             upd_mispredict = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] mispred_cnt;

  btb_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .lk_pc(lk_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next(pred_next),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .flush(flush), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lk;
    int hit;
    int taken;
    int nxt;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  // Reference model: one record per table slot, slot chosen by word address modulo ENTRIES.
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_ctr   [ENTRIES];
  int m_cnt;

  function automatic int slot_of(input int pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int tag_of(input int pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_tgt[i]   = 0;
      m_tag[i]   = 0;
    end
    m_cnt = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp, input int pc);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s lk_pc=0x%03h got=0x%0h expected=0x%0h", name, pc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the lookup from pre-edge state, then advance the model.
  task automatic drive(input bit r, input int lk, input bit uv, input int upc, input bit ut,
                       input int utg, input bit um, input bit fl);
    exp_t e;
    int   s;
    int   h;
    @(posedge clk);
    #1;
    rst            = r;
    lk_pc          = PC_W'(lk);
    upd_valid      = uv;
    upd_pc         = PC_W'(upc);
    upd_taken      = ut;
    upd_target     = PC_W'(utg);
    upd_mispredict = um;
    flush          = fl;
    if (r) model_reset();
    s       = slot_of(lk);
    e.lk    = lk;
    e.hit   = (m_valid[s] && m_tag[s] == tag_of(lk)) ? 1 : 0;
    e.taken = (e.hit == 1 && m_ctr[s] >= 2) ? 1 : 0;
    e.nxt   = (e.taken == 1) ? m_tgt[s] : (lk + 4) % (1 << PC_W);
    e.cnt   = m_cnt;
    sbq.push_back(e);
    if (!r) begin
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (uv) begin
        s = slot_of(upc);
        h = (m_valid[s] && m_tag[s] == tag_of(upc)) ? 1 : 0;
        if (h == 1) begin
          if (ut) begin
            m_tgt[s] = utg;
            if (m_ctr[s] < 3) m_ctr[s]++;
          end else if (m_ctr[s] > 0) begin
            m_ctr[s]--;
          end
        end else if (ut) begin
          m_valid[s] = 1'b1;
          m_tag[s]   = tag_of(upc);
          m_tgt[s]   = utg;
          m_ctr[s]   = 2;
        end
      end
      if (uv && um && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pred_hit",    int'(pred_hit),    e.hit,   e.lk);
      chk("pred_taken",  int'(pred_taken),  e.taken, e.lk);
      chk("pred_next",   int'(pred_next),   e.nxt,   e.lk);
      chk("mispred_cnt", int'(mispred_cnt), e.cnt,   e.lk);
    end
  end

  function automatic int rand_pc();
    return ($urandom_range(0, 3) * 64) + ($urandom_range(0, ENTRIES - 1) * 4)
           + $urandom_range(0, 3) + ($urandom_range(0, 7) == 0 ? 12'hF00 : 0);
  endfunction

  initial begin
    model_reset();
    // Reset-state lookups, including the +4 wrap at the top of the PC space.
    drive(1, 'h040, 0, 0, 0, 0, 0, 0);
    drive(0, 'h040, 0, 0, 0, 0, 0, 0);
    drive(0, 'hFFC, 0, 0, 0, 0, 0, 0);
    // Allocate; same-cycle lookup still sees the old contents.
    drive(0, 'h040, 1, 'h040, 1, 'h100, 0, 0);
    drive(0, 'h040, 1, 'h040, 0, 0, 0, 0);
    drive(0, 'h040, 1, 'h040, 0, 0, 0, 0);
    drive(0, 'h040, 1, 'h040, 0, 0, 0, 0);
    drive(0, 'h040, 0, 0, 0, 0, 0, 0);
    // Conflicting tag at the same slot replaces the occupant.
    drive(0, 'h040, 1, 'h440, 1, 'h200, 0, 0);
    drive(0, 'h040, 0, 0, 0, 0, 0, 0);
    drive(0, 'h440, 0, 0, 0, 0, 0, 0);
    // Flush together with a taken update: the update is dropped.
    drive(0, 'h440, 1, 'h080, 1, 'h300, 0, 1);
    drive(0, 'h080, 0, 0, 0, 0, 0, 0);
    drive(0, 'h440, 0, 0, 0, 0, 0, 0);
    // Mispredict counter saturates at all-ones.
    for (int i = 0; i < 20; i++) drive(0, 'h040, 1, rand_pc(), 0, 0, 1, 0);
    drive(0, 'h040, 0, 0, 0, 0, 0, 0);
    // Random traffic over a small PC pool so hits, conflicts and saturation all occur.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) == 0), rand_pc(), $urandom_range(0, 3) != 0, rand_pc(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 4095), $urandom_range(0, 3) == 0,
            $urandom_range(0, 39) == 0);
    end
    // Asynchronous reset raised mid-cycle with an update in flight.
    for (int i = 0; i < 20; i++) drive(0, 'h440, 1, rand_pc(), 0, 0, 1, 0);
    drive(0, 'h440, 1, 'h440, 1, 'h300, 0, 0);
    drive(1, 'h440, 1, 'h440, 1, 'h300, 1, 0);
    drive(0, 'h440, 0, 0, 0, 0, 0, 0);
    drive(0, 'h440, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
